// File: rtl/reg_mem_arbiter_pkg.sv
// Shared types and helpers for the register-memory arbiter and any other
// round-robin arbiter built on rr_arbiter.
package reg_mem_arb_pkg;

  localparam int NREQ_MAX = 16;

  function automatic int calc_aw(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  function automatic int calc_idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Ids are sized for the largest supported requester count so one type
  // serves every arbiter instance regardless of its own N.
  localparam int IDW_MAX = calc_idw(NREQ_MAX);

  typedef logic [IDW_MAX-1:0] req_id_t;

  // Returns {found, id}: first valid requester scanning upward from ptr+1 mod n.
  function automatic logic [IDW_MAX:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                               input req_id_t ptr,
                                               input int unsigned n);
    logic        found;
    req_id_t     id;
    int unsigned idx;
    found = 1'b0;
    id    = '0;
    for (int unsigned i = 1; i <= NREQ_MAX; i++) begin
      if (i <= n) begin
        idx = 32'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx[IDW_MAX-1:0]]) begin
          found = 1'b1;
          id    = idx[IDW_MAX-1:0];
        end
      end
    end
    return {found, id};
  endfunction

endpackage

// File: rtl/reg_mem_arbiter_if.sv
// Requester, response and memory-side signals of the register-memory arbiter.
// master = requesters plus the memory instance, slave = the arbiter.
interface reg_mem_arbiter_if import reg_mem_arb_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int NREQ   = 4
);
  localparam int AW = calc_aw(HEIGHT);

  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ-1:0]       req_write_i;
  logic [NREQ*AW-1:0]    req_addr_i;
  logic [NREQ*WIDTH-1:0] req_wdata_i;
  logic [NREQ-1:0]       rsp_valid_o;
  logic [WIDTH-1:0]      rsp_rdata_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [AW-1:0]         mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic [WIDTH-1:0]      mem_rdata_i;
  logic                  mem_hold_i;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i, mem_hold_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i, mem_hold_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/reg_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant plus winner id, priority
// starting just above the last winner held in ptr_i.
module rr_arbiter import reg_mem_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0] valid_i,
  input  req_id_t      ptr_i,
  output logic [N-1:0] grant_o,
  output req_id_t      id_o,
  output logic         found_o
);

  logic [NREQ_MAX-1:0] valid_ext;

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = valid_i;
    {found_o, id_o}    = rr_pick(valid_ext, ptr_i, N);
    grant_o            = found_o ? (N'(1) << id_o) : '0;
  end

endmodule

// File: rtl/reg_mem_arbiter.sv
// Shares one single-port 1-cycle-latency register memory between NREQ
// requesters with round-robin grant and a routed 1-cycle-later response.
module reg_mem_arbiter import reg_mem_arb_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int NREQ   = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  reg_mem_arbiter_if.slave  bus
);

  localparam int AW = calc_aw(HEIGHT);

  req_id_t         ptr_q;
  req_id_t         win_id;
  req_id_t         pend_id_q;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            accept;
  logic            pend_valid_q;
  logic            rsp_present;

  rr_arbiter #(.N(NREQ)) u_rr (
    .valid_i (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .id_o    (win_id),
    .found_o (found)
  );

  // Reset is folded into the handshake so nothing reaches the memory or the
  // requesters while rst_ni is low, even before the flops have cleared.
  assign accept      = rst_ni & found & ~bus.mem_hold_i;
  assign rsp_present = rst_ni & pend_valid_q & ~bus.mem_hold_i;

  always_comb begin
    bus.req_ready_o  = (rst_ni && !bus.mem_hold_i) ? grant : '0;
    bus.mem_enable_o = accept;
    bus.mem_write_o  = accept & |(grant & bus.req_write_i);
    bus.mem_addr_o   = bus.req_addr_i[0 +: AW];
    bus.mem_wdata_o  = bus.req_wdata_i[0 +: WIDTH];
    for (int k = 0; k < NREQ; k++) begin
      if (accept && grant[k]) begin
        bus.mem_addr_o  = bus.req_addr_i[k*AW +: AW];
        bus.mem_wdata_o = bus.req_wdata_i[k*WIDTH +: WIDTH];
      end
    end
    bus.rsp_valid_o  = rsp_present ? (NREQ'(1) << pend_id_q) : '0;
    bus.rsp_rdata_o  = rsp_present ? bus.mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= req_id_t'(NREQ - 1);
    end else if (accept) begin
      ptr_q <= win_id;
    end
  end

  // A new accept re-arms the pending slot in the same cycle the old response
  // leaves, which is what sustains one operation per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
    end else if (accept) begin
      pend_valid_q <= 1'b1;
      pend_id_q    <= win_id;
    end else if (rsp_present) begin
      pend_valid_q <= 1'b0;
    end
  end

endmodule
